// File: rtl/lvds_clk_pattern_gen.sv
// rtl/lvds_clk_pattern_gen.sv - 7:1 LVDS clock-lane pattern generator with warm-up and per-lane phase trim
module lvds_clk_pattern_gen #(
    parameter int                 NUM_CH        = 2,
    parameter int                 SER_W         = 7,
    parameter logic [SER_W-1:0]   DEFAULT_PAT   = 7'b1100011,
    parameter int                 WARMUP_CYCLES = 16,
    parameter int                 HOLDOFF       = 4,
    parameter int                 CH_W          = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                      I_clk,
    input  logic                      I_rst_n,
    input  logic                      I_en,
    input  logic                      I_pat_wr,
    input  logic [SER_W-1:0]          I_pat_data,
    input  logic                      I_rot_req,
    input  logic                      I_rot_dir,
    input  logic [CH_W-1:0]           I_rot_ch,
    output logic [NUM_CH*SER_W-1:0]   O_data,
    output logic                      O_valid,
    output logic                      O_busy,
    output logic                      O_pat_err,
    output logic [1:0]                O_state
);

    localparam int OFF_W = (SER_W > 1) ? $clog2(SER_W) : 1;
    localparam int WC_W  = $clog2(WARMUP_CYCLES + 1);
    localparam int HO_W  = $clog2(HOLDOFF + 1);
    localparam logic [OFF_W-1:0] OFF_MAX = OFF_W'(SER_W - 1);
    localparam logic [WC_W-1:0]  WC_LAST = WC_W'(WARMUP_CYCLES - 1);
    localparam logic [HO_W-1:0]  HO_LOAD = HO_W'(HOLDOFF - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WARMUP = 2'd1,
        ST_RUN    = 2'd2
    } state_t;

    state_t                    state_q, state_d;
    logic [WC_W-1:0]           wcnt_q, wcnt_d;
    logic [SER_W-1:0]          pat_q, pat_d;
    logic [OFF_W-1:0]          off_q [NUM_CH];
    logic [OFF_W-1:0]          off_d [NUM_CH];
    logic                      busy_q, busy_d;
    logic [HO_W-1:0]           hcnt_q, hcnt_d;
    logic                      err_q, err_d;
    logic                      valid_q, valid_d;
    logic [NUM_CH*SER_W-1:0]   data_q, data_d;
    logic [31:0]               ch_ext;
    logic                      ch_valid;
    logic                      rot_ok;

    // Offset n means the pattern is rotated left by n bit positions.
    function automatic logic [SER_W-1:0] rotl(input logic [SER_W-1:0] d, input logic [OFF_W-1:0] n);
        logic [2*SER_W-1:0] t;
        t = {d, d} << n;
        return t[2*SER_W-1:SER_W];
    endfunction

    assign ch_ext   = 32'(I_rot_ch);
    assign ch_valid = ch_ext < 32'(NUM_CH);
    assign rot_ok   = I_rot_req && !busy_q && ch_valid;

    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        wcnt_d  = '0;
        case (state_q)
            ST_IDLE: begin
                if (I_en) state_d = ST_WARMUP;
            end
            ST_WARMUP: begin
                if (!I_en) begin
                    state_d = ST_IDLE;
                end else if (wcnt_q == WC_LAST) begin
                    state_d = ST_RUN;
                end else begin
                    wcnt_d = wcnt_q + 1'b1;
                end
            end
            ST_RUN: begin
                if (!I_en) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        pat_d = (I_pat_wr && state_q == ST_IDLE) ? I_pat_data : pat_q;
        err_d = (I_pat_wr && state_q != ST_IDLE) || (I_rot_req && !ch_valid);

        for (int k = 0; k < NUM_CH; k++) begin
            off_d[k] = off_q[k];
            if (rot_ok && ch_ext == 32'(k)) begin
                if (I_rot_dir) off_d[k] = (off_q[k] == '0) ? OFF_MAX : off_q[k] - 1'b1;
                else           off_d[k] = (off_q[k] == OFF_MAX) ? '0 : off_q[k] + 1'b1;
            end
        end

        busy_d = busy_q;
        hcnt_d = hcnt_q;
        if (rot_ok) begin
            busy_d = 1'b1;
            hcnt_d = HO_LOAD;
        end else if (busy_q) begin
            if (hcnt_q == '0) busy_d = 1'b0;
            else              hcnt_d = hcnt_q - 1'b1;
        end

        // Data is built from next-state values so the first RUN word lines up with O_valid.
        valid_d = (state_d == ST_RUN);
        data_d  = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (valid_d) data_d[k*SER_W +: SER_W] = rotl(pat_d, off_d[k]);
        end
    end

    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            wcnt_q  <= '0;
            pat_q   <= DEFAULT_PAT;
            busy_q  <= 1'b0;
            hcnt_q  <= '0;
            err_q   <= 1'b0;
            valid_q <= 1'b0;
            data_q  <= '0;
            for (int k = 0; k < NUM_CH; k++) off_q[k] <= '0;
        end else begin
            wcnt_q  <= wcnt_d;
            pat_q   <= pat_d;
            busy_q  <= busy_d;
            hcnt_q  <= hcnt_d;
            err_q   <= err_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            for (int k = 0; k < NUM_CH; k++) off_q[k] <= off_d[k];
        end
    end

    assign O_data    = data_q;
    assign O_valid   = valid_q;
    assign O_busy    = busy_q;
    assign O_pat_err = err_q;
    assign O_state   = state_q;

endmodule
